// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the FP unit scheduler.
package fp_sched_pkg;

  localparam int unsigned FP_W = 32;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_ADD = 1'b1
  } fp_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RETURN = 2'd2
  } unit_state_e;

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/fp_unit_slot.sv
// One shared FP unit: round-robin arbiter, IDLE/BUSY/RETURN sequencer and
// the operand/owner/count registers that front the unit.
module fp_unit_slot
  import fp_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LAT     = 2,
  parameter fp_op_e      OP      = OP_MUL
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ-1:0]        out_mask,
  input  logic [NUM_REQ*FP_W-1:0]   req_a,
  input  logic [NUM_REQ*FP_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]        gnt_c,
  output logic                      cap_c,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic [FP_W-1:0]           op_a,
  output logic [FP_W-1:0]           op_b
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(LAT + 2);

  unit_state_e          state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FP_W-1:0]      a_q, a_d;
  logic [FP_W-1:0]      b_q, b_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0]   op_match;
  logic [NUM_REQ-1:0]   elig;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand;

  assign op_match = (OP == OP_ADD) ? req_op : ~req_op;
  assign elig     = req_valid & ~out_mask & op_match;

  // First eligible index at or after ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = '0;
    gnt_c       = '0;
    cap_c       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_c[win_idx] = 1'b1;
          a_d            = req_a[FP_W*win_idx +: FP_W];
          b_d            = req_b[FP_W*win_idx +: FP_W];
          owner_d        = win_idx;
          ptr_d          = IDX_W'((32'(win_idx) + 1) % NUM_REQ);
          // Extra cycle: the unit only sees operands once they are registered.
          cnt_d          = CNT_W'(LAT + 1);
          state_d        = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          cap_c                = 1'b1;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = RETURN;
        end
      end
      RETURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      a_q         <= FP_ZERO;
      b_q         <= FP_ZERO;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign owner     = owner_q;
  assign op_a      = a_q;
  assign op_b      = b_q;

endmodule

// File: rtl/fp_unit_scheduler.sv
// Shares one FP multiplier and one FP adder among NUM_REQ layer controllers,
// returning each result to its owner with a one-cycle valid.
module fp_unit_scheduler
  import fp_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned ADD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_op,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [NUM_REQ*FP_W-1:0] rsp_data,
  output logic [FP_W-1:0]         mul_a,
  output logic [FP_W-1:0]         mul_b,
  input  logic [FP_W-1:0]         mul_q,
  output logic [FP_W-1:0]         add_a,
  output logic [FP_W-1:0]         add_b,
  input  logic [FP_W-1:0]         add_q
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      out_q, out_d;
  logic [NUM_REQ*FP_W-1:0] rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] mul_gnt_c, add_gnt_c;
  logic [NUM_REQ-1:0] mul_rsp_valid, add_rsp_valid;
  logic               mul_cap_c, add_cap_c;
  logic [IDX_W-1:0]   mul_owner, add_owner;

  fp_unit_slot #(
    .NUM_REQ (NUM_REQ),
    .LAT     (MUL_LAT),
    .OP      (OP_MUL)
  ) u_mul_slot (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .out_mask  (out_q),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt_c     (mul_gnt_c),
    .cap_c     (mul_cap_c),
    .rsp_valid (mul_rsp_valid),
    .owner     (mul_owner),
    .op_a      (mul_a),
    .op_b      (mul_b)
  );

  fp_unit_slot #(
    .NUM_REQ (NUM_REQ),
    .LAT     (ADD_LAT),
    .OP      (OP_ADD)
  ) u_add_slot (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .out_mask  (out_q),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt_c     (add_gnt_c),
    .cap_c     (add_cap_c),
    .rsp_valid (add_rsp_valid),
    .owner     (add_owner),
    .op_a      (add_a),
    .op_b      (add_b)
  );

  assign gnt       = mul_gnt_c | add_gnt_c;
  assign rsp_valid = mul_rsp_valid | add_rsp_valid;
  assign rsp_data  = rsp_data_q;

  // Owners of the two units are always distinct, so both captures can land together.
  always_comb begin
    out_d      = (out_q | gnt) & ~rsp_valid;
    rsp_data_d = rsp_data_q;
    if (mul_cap_c) rsp_data_d[FP_W*mul_owner +: FP_W] = mul_q;
    if (add_cap_c) rsp_data_d[FP_W*add_owner +: FP_W] = add_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      out_q      <= out_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule
